inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter PC_STEP, default 4, which is the byte increment added to the PC per sequential fetch.
REQ-002 SHALL have port clk, input, 1b: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1b: synchronous, active-high reset.
REQ-004 SHALL have port pc_cur, input, 8b: current PC from the PC register.
REQ-005 SHALL have port pc_next, output, 8b: next PC value driven to the PC register input.
REQ-006 SHALL have port stall, input, 1b: when high, no new fetch request is issued.
REQ-007 SHALL have port redirect_valid, input, 1b: branch/jump redirect strobe.
REQ-008 SHALL have port redirect_pc, input, 8b: redirect target.
REQ-009 SHALL have port imem_req, output, 1b: single-cycle instruction memory request pulse.
REQ-010 SHALL have port imem_addr, output, 8b: request address.
REQ-011 SHALL have port imem_rvalid, input, 1b: response strobe, arriving 1 or more cycles after imem_req.
REQ-012 SHALL have port imem_rdata, input, 32b: response instruction word.
REQ-013 SHALL have port inst_valid, output, 1b: buffered instruction available.
REQ-014 SHALL have port inst_ready, input, 1b: downstream accepts the instruction.
REQ-015 SHALL have port inst_out, output, 32b: instruction at the buffer head.
REQ-016 SHALL have port inst_pc, output, 8b: fetch address of inst_out.

Function
REQ-017 SHALL keep at most one memory request outstanding, tracked by FSM states IDLE, WAIT and DROP.
REQ-018 In IDLE, SHALL issue a request (imem_req=1, imem_addr=pc_cur, go to WAIT) when stall=0, redirect_valid=0 and count+0 < 2, where count is the buffer occupancy 0..2.
REQ-019 In WAIT, on imem_rvalid SHALL push {imem_rdata, request address} into the 2-entry FIFO and return to IDLE; a new request SHALL NOT issue in the same cycle.
REQ-020 In DROP, on imem_rvalid SHALL discard the response and return to IDLE.
REQ-021 pc_next SHALL be combinational: redirect_pc if redirect_valid, else pc_cur+PC_STEP (mod 256) in a request-issue cycle, else pc_cur.
REQ-022 8'hFC+4 SHALL wrap to 8'h00 with no error.
REQ-023 redirect_valid SHALL flush the FIFO (count set to 0 next cycle), move WAIT to DROP, and leave IDLE or DROP unchanged.
REQ-024 redirect_valid SHALL take priority over stall, over a same-cycle imem_rvalid (the response is dropped) and over a same-cycle pop.
REQ-025 A pop (inst_valid && inst_ready) and a push in the same cycle SHALL leave count unchanged, with FIFO order preserved.
REQ-026 inst_valid SHALL equal (count != 0); inst_out/inst_pc SHALL show the head entry and hold stable while inst_valid && !inst_ready.
REQ-027 A push with count==2 SHALL be impossible by construction (REQ-018); the bench checks this with an assertion.
REQ-028 Fetch-to-inst_valid latency SHALL be memory latency + 1 cycle (registered FIFO write).

Reset
REQ-029 While rst=1 at a clock edge: FSM=IDLE, count=0, FIFO pointers=0, imem_req=0, inst_valid=0, inst_out=0, inst_pc=0.
REQ-030 While rst=1, pc_next SHALL be 8'h00 and imem_rvalid SHALL be ignored.
REQ-031 Reset mid-WAIT SHALL abandon the request; a late response after reset release SHALL be dropped because the block enters DROP for one response when reset is released with a request outstanding.

Configuration
REQ-032 Macro IF_STALL_CNT_EN, when defined, SHALL add output stall_cnt (16b): increments each cycle inst_valid=1 && inst_ready=0, saturates at 16'hFFFF, and clears on rst.
REQ-033 Without IF_STALL_CNT_EN, the port and counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-034 Reset, then pc_cur=0x00 with 1-cycle memory latency and inst_ready=1 -> imem_addr sequence 0x00,0x04,0x08; inst_pc matches; pc_next=0x04 in the first issue cycle.
REQ-035 inst_ready=0 held -> exactly 2 instructions buffered, imem_req stops, inst_out stable; release -> drains in order.
REQ-036 redirect_valid=1, redirect_pc=0x40 while in WAIT -> pending rdata discarded, FIFO empty, next imem_addr=0x40.
REQ-037 pc_cur=0xFC, issue -> pc_next=0x00.
REQ-038 redirect_valid and imem_rvalid in the same cycle -> no push, inst_valid=0 next cycle.
REQ-039 With IF_STALL_CNT_EN: 5 cycles of valid&&!ready -> stall_cnt=5; rst -> 0.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch with one outstanding request and 2-entry buffer
// Optional: define IF_STALL_CNT_EN to add the stall_cnt backpressure counter output.
module inst_fetch #(
    parameter int PC_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pc_cur,
    output logic [7:0]  pc_next,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [7:0]  inst_pc
`ifdef IF_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state, state_nxt;
    logic        pend_drop;
    logic [1:0]  count;
    logic        wr_ptr, rd_ptr;
    logic [31:0] buf_data [2];
    logic [7:0]  buf_pc   [2];
    logic [7:0]  req_addr;
    logic        issue, push, pop;

    // A response in WAIT always closes the request; redirect only decides whether it is kept.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (pend_drop) begin
                    state_nxt = DROP;
                end else if (!stall && !redirect_valid && count < 2'd2) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push      = !redirect_valid;
                    state_nxt = IDLE;
                end else if (redirect_valid) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            issue     = 1'b0;
            push      = 1'b0;
            state_nxt = IDLE;
        end
    end

    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign imem_req   = issue;
    assign imem_addr  = pc_cur;
    assign inst_valid = (count != 2'd0);
    assign inst_out   = buf_data[rd_ptr];
    assign inst_pc    = buf_pc[rd_ptr];

    always_comb begin
        pc_next = pc_cur;
        if (rst) begin
            pc_next = 8'h00;
        end else if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (issue) begin
            pc_next = pc_cur + 8'(PC_STEP);
        end
    end

    // pend_drop remembers a request abandoned by reset so its late response is swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_drop <= imem_rvalid ? 1'b0 : (pend_drop || state == WAIT || state == DROP);
        end else if (state == DROP && imem_rvalid) begin
            pend_drop <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            req_addr <= 8'h00;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= 32'h0;
                buf_pc[i]   <= 8'h00;
            end
        end else begin
            state <= state_nxt;
            if (issue) begin
                req_addr <= pc_cur;
            end
            if (redirect_valid) begin
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    buf_data[wr_ptr] <= imem_rdata;
                    buf_pc[wr_ptr]   <= req_addr;
                    wr_ptr           <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

`ifdef IF_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if (inst_valid && !inst_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pc_cur = 8'h00;
    logic [7:0]  pc_next;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_out;
    logic [7:0]  inst_pc;
`ifdef IF_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;
    logic       mpend = 1'b0;
    int         mcnt  = 0;
    logic [7:0] maddr = 8'h00;

    inst_fetch #(.PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc)
`ifdef IF_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [7:0] a);
        return {8'hE5, a, 8'h3C, ~a};
    endfunction

    // External PC register
    always @(posedge clk) pc_cur <= pc_next;

    // Memory with programmable latency (cycles from request cycle to rvalid cycle)
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (mpend) begin
            if (mcnt <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word(maddr);
                mpend       <= 1'b0;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
        if (imem_req) begin
            if (lat <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word(imem_addr);
            end else begin
                mpend <= 1'b1;
                maddr <= imem_addr;
                mcnt  <= lat - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(dut.push && dut.count == 2'd2)) else begin
                n_fail++;
                $display("FAIL fifo_overflow: push with count %0d, required below 2", dut.count);
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        inst_ready = 1'b1; lat = 1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h55;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        n_checks++; if (inst_out !== 32'h0) begin n_fail++; $display("FAIL rst_out: got %h want 0", inst_out); end
        n_checks++; if (inst_pc !== 8'h00) begin n_fail++; $display("FAIL rst_pc: got %h want 00", inst_pc); end
        n_checks++; if (pc_next !== 8'h00) begin n_fail++; $display("FAIL rst_pc_next: got %h want 00", pc_next); end
        redirect_valid = 1'b0;
    endtask

    task automatic test_sequential;
        logic [7:0] exp_addr, exp_pc;
        int issues, pops;
        do_reset;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin n_fail++; $display("FAIL seq_first_req: got req %b addr %h want 1 00", imem_req, imem_addr); end
        n_checks++; if (pc_next !== 8'h04) begin n_fail++; $display("FAIL seq_pc_next: got %h want 04", pc_next); end
        exp_addr = 8'h04; exp_pc = 8'h00; issues = 1; pops = 0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk); #1;
            if (c == 2) begin
                n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL seq_latency: valid %b want 1 at cycle 2", inst_valid); end
            end
            if (imem_req) begin
                n_checks++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL seq_addr: got %h want %h", imem_addr, exp_addr); end
                exp_addr += 8'd4; issues++;
            end
            if (inst_valid && inst_ready) begin
                n_checks++; if (inst_pc !== exp_pc || inst_out !== word(exp_pc)) begin n_fail++; $display("FAIL seq_inst: got %h/%h want %h/%h", inst_pc, inst_out, exp_pc, word(exp_pc)); end
                exp_pc += 8'd4; pops++;
            end
        end
        n_checks++; if (issues != 4 || pops != 3) begin n_fail++; $display("FAIL seq_counts: issues %0d pops %0d want 4 3", issues, pops); end
    endtask

    task automatic test_backpressure;
        int issues;
        do_reset;
        inst_ready = 1'b0;
        issues = imem_req ? 1 : 0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk); #1;
            if (imem_req) issues++;
            if (c >= 2) begin
                n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00 || inst_out !== word(8'h00)) begin n_fail++; $display("FAIL bp_hold: valid %b pc %h out %h want 1 00 %h", inst_valid, inst_pc, inst_out, word(8'h00)); end
            end
        end
        n_checks++; if (issues != 2) begin n_fail++; $display("FAIL bp_issues: got %0d want 2", issues); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_stop: got %b want 0", imem_req); end
        stall = 1'b1; inst_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h04 || inst_out !== word(8'h04)) begin n_fail++; $display("FAIL bp_drain2: valid %b pc %h want 1 04", inst_valid, inst_pc); end
        @(negedge clk); #1;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: valid %b want 0", inst_valid); end
        stall = 1'b0;
    endtask

    task automatic test_push_pop;
        do_reset;
        inst_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin n_fail++; $display("FAIL pp_issue: req %b addr %h want 1 04", imem_req, imem_addr); end
        @(negedge clk);
        inst_ready = 1'b1; stall = 1'b1; #1;
        n_checks++; if (imem_rvalid !== 1'b1 || inst_pc !== 8'h00) begin n_fail++; $display("FAIL pp_same_cycle: rvalid %b pc %h want 1 00", imem_rvalid, inst_pc); end
        @(negedge clk);
        inst_ready = 1'b0; #1;
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'h04 || inst_out !== word(8'h04)) begin n_fail++; $display("FAIL pp_order: valid %b pc %h want 1 04", inst_valid, inst_pc); end
        @(negedge clk);
        inst_ready = 1'b1; #1;
        @(negedge clk); #1;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL pp_count: valid %b want 0", inst_valid); end
        stall = 1'b0;
    endtask

    task automatic test_redirect_wait;
        logic found, seen;
        do_reset;
        inst_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        lat = 4; #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin n_fail++; $display("FAIL rw_issue: req %b addr %h want 1 04", imem_req, imem_addr); end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 8'h40; #1;
        n_checks++; if (pc_next !== 8'h40 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_pc_next: pc_next %h req %b want 40 0", pc_next, imem_req); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rw_flush: valid %b want 0", inst_valid); end
        found = 1'b0; seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (imem_req) begin found = 1'b1; break; end
            if (inst_valid) seen = 1'b1;
            @(negedge clk); #1;
        end
        n_checks++; if (!found || imem_addr !== 8'h40 || seen) begin n_fail++; $display("FAIL rw_next_addr: found %b addr %h stale %b want 1 40 0", found, imem_addr, seen); end
        @(negedge clk);
        stall = 1'b1; inst_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (inst_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!found || inst_pc !== 8'h40 || inst_out !== word(8'h40)) begin n_fail++; $display("FAIL rw_data: found %b pc %h out %h want 1 40 %h", found, inst_pc, inst_out, word(8'h40)); end
        stall = 1'b0;
    endtask

    task automatic test_wrap;
        do_reset;
        stall = 1'b1; #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_stall: req %b want 0", imem_req); end
        @(negedge clk);
        stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'hFC; #1;
        n_checks++; if (imem_req !== 1'b0 || pc_next !== 8'hFC) begin n_fail++; $display("FAIL wrap_redirect: req %b pc_next %h want 0 fc", imem_req, pc_next); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'hFC || pc_next !== 8'h00) begin n_fail++; $display("FAIL wrap_issue: req %b addr %h pc_next %h want 1 fc 00", imem_req, imem_addr, pc_next); end
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 8'hFC) begin n_fail++; $display("FAIL wrap_inst: valid %b pc %h want 1 fc", inst_valid, inst_pc); end
        stall = 1'b0;
    endtask

    task automatic test_redirect_rvalid;
        logic found;
        do_reset;
        lat = 3;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_rvalid) begin found = 1'b1; break; end
        end
        redirect_valid = 1'b1; redirect_pc = 8'h80; #1;
        n_checks++; if (!found || imem_req !== 1'b0) begin n_fail++; $display("FAIL rr_rvalid: seen %b req %b want 1 0", found, imem_req); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rr_no_push: valid %b want 0", inst_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h80) begin n_fail++; $display("FAIL rr_next: req %b addr %h want 1 80", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_wait;
        logic found, seen;
        int idx;
        do_reset;
        lat = 4;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mw_issue: req %b want 1", imem_req); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        found = 1'b0; seen = 1'b0; idx = -1;
        for (int c = 0; c < 12; c++) begin
            if (imem_req) begin found = 1'b1; idx = c; break; end
            if (inst_valid) seen = 1'b1;
            @(negedge clk); #1;
        end
        n_checks++; if (!found || idx != 3 || imem_addr !== 8'h00) begin n_fail++; $display("FAIL mw_reissue: found %b cycle %0d addr %h want 1 3 00", found, idx, imem_addr); end
        n_checks++; if (seen) begin n_fail++; $display("FAIL mw_late_drop: stale response pushed, want dropped"); end
    endtask

`ifdef IF_STALL_CNT_EN
    task automatic test_stall_cnt;
        do_reset;
        inst_ready = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (inst_valid !== 1'b1 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL sc_start: valid %b cnt %0d want 1 0", inst_valid, stall_cnt); end
        repeat (5) @(negedge clk);
        inst_ready = 1'b1; #1;
        n_checks++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL sc_count: got %0d want 5", stall_cnt); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL sc_reset: got %0d want 0", stall_cnt); end
        rst = 1'b0; stall = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_sequential;
        test_backpressure;
        test_push_pop;
        test_redirect_wait;
        test_wrap;
        test_redirect_rvalid;
        test_reset_mid_wait;
`ifdef IF_STALL_CNT_EN
        test_stall_cnt;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
